// File: rtl/dsi_pkg.sv
// Shared DSI definitions for the packet assembler and parser: data types,
// long/short classification, header ECC and the parser state encoding.
package dsi_pkg;

    localparam logic [5:0] DT_VSS    = 6'h01;
    localparam logic [5:0] DT_VSE    = 6'h11;
    localparam logic [5:0] DT_HSS    = 6'h21;
    localparam logic [5:0] DT_HSE    = 6'h31;
    localparam logic [5:0] DT_NULL   = 6'h09;
    localparam logic [5:0] DT_BLANK  = 6'h19;
    localparam logic [5:0] DT_RGB888 = 6'h3E;

    typedef enum logic [1:0] {
        S_HDR     = 2'd0,
        S_PAYLOAD = 2'd1,
        S_DROP    = 2'd2
    } state_t;

    function automatic logic is_long_dt(input logic [5:0] dt);
        return (dt[3:0] == 4'h9) || (dt[3:0] == 4'hC) ||
               (dt[3:0] == 4'hD) || (dt[3:0] == 4'hE);
    endfunction

    // Every data column has odd weight, so any double error leaves an even,
    // non-zero syndrome that matches neither a column nor a parity bit.
    function automatic logic [5:0] dsi_ecc24(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

endpackage

// File: rtl/dsi_crc16_4b.sv
// Combinational CRC-16/CCITT (reflected 0x8408) step over the low nbytes of a word.
// Only present when DSI_PARSER_CRC_EN is defined.
`ifdef DSI_PARSER_CRC_EN
module dsi_crc16_4b (
    input  logic [15:0] crc_in,
    input  logic [31:0] data,
    input  logic [2:0]  nbytes,
    output logic [15:0] crc_out
);
    logic [15:0] c;

    always_comb begin
        c = crc_in;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < nbytes) begin
                c = c ^ {8'h00, data[8*b +: 8]};
                for (int i = 0; i < 8; i++) begin
                    c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
                end
            end
        end
        crc_out = c;
    end
endmodule
`endif

// File: rtl/dsi_packet_parser.sv
// DSI receive parser: header ECC check/correct, short-packet events, long-packet
// payload to the pixel FIFO. Define DSI_PARSER_CRC_EN to enable the payload CRC check.
module dsi_packet_parser
    import dsi_pkg::*;
#(
    parameter logic [1:0] VC_ID = 2'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_sop,
    output logic        in_ready,
    output logic [31:0] pix_fifo_data,
    output logic [3:0]  pix_fifo_be,
    output logic        pix_fifo_first,
    output logic        pix_fifo_last,
    output logic        pix_fifo_write,
    input  logic        pix_fifo_full,
    output logic        evt_valid,
    output logic [5:0]  evt_dt,
    output logic [15:0] evt_data,
    output logic        ecc_corrected,
    output logic        ecc_error,
    output logic        crc_error,
    output logic        trunc_error
);
    state_t      state;
    logic [15:0] bytes_left;
    logic [15:0] words_left;
    logic        first_pend;
    logic        wr_en;
    logic        accept;

    logic [23:0] hdr;
    logic [5:0]  syn;
    logic        hit;
    logic        hdr_corr;
    logic        hdr_bad;
    logic [5:0]  hdr_dt;
    logic [15:0] hdr_wc;
    logic        hdr_vc_ok;
    logic        hdr_long;
    logic [2:0]  n;
    logic        last_word;

    assign in_ready  = !(state == S_PAYLOAD && pix_fifo_full);
    assign accept    = in_valid && in_ready;
    assign n         = (bytes_left > 16'd4) ? 3'd4 : bytes_left[2:0];
    assign last_word = (words_left == 16'd1);

    always_comb begin
        hdr      = in_data[23:0];
        syn      = dsi_ecc24(in_data[23:0]) ^ in_data[29:24];
        hit      = 1'b0;
        hdr_corr = 1'b0;
        hdr_bad  = 1'b0;
        if (in_data[31:30] != 2'b00) begin
            hdr_bad = 1'b1;
        end else if (syn != 6'd0) begin
            for (int i = 0; i < 24; i++) begin
                if (syn == dsi_ecc24(24'd1 << i)) begin
                    hdr[i] = ~hdr[i];
                    hit    = 1'b1;
                end
            end
            // A lone parity-bit error leaves the header data intact.
            if ($onehot(syn)) hit = 1'b1;
            hdr_corr = hit;
            hdr_bad  = !hit;
        end
    end

    assign hdr_dt    = hdr[5:0];
    assign hdr_wc    = hdr[23:8];
    assign hdr_vc_ok = (hdr[7:6] == VC_ID);
    assign hdr_long  = is_long_dt(hdr_dt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_HDR;
            bytes_left     <= '0;
            words_left     <= '0;
            first_pend     <= 1'b0;
            wr_en          <= 1'b0;
            pix_fifo_data  <= '0;
            pix_fifo_be    <= '0;
            pix_fifo_first <= 1'b0;
            pix_fifo_last  <= 1'b0;
            pix_fifo_write <= 1'b0;
            evt_valid      <= 1'b0;
            evt_dt         <= '0;
            evt_data       <= '0;
            ecc_corrected  <= 1'b0;
            ecc_error      <= 1'b0;
            trunc_error    <= 1'b0;
        end else begin
            pix_fifo_write <= 1'b0;
            pix_fifo_first <= 1'b0;
            pix_fifo_last  <= 1'b0;
            evt_valid      <= 1'b0;
            ecc_corrected  <= 1'b0;
            ecc_error      <= 1'b0;
            trunc_error    <= 1'b0;
            if (accept && in_sop) begin
                trunc_error   <= (state == S_PAYLOAD);
                ecc_corrected <= hdr_corr;
                ecc_error     <= hdr_bad;
                if (hdr_bad) begin
                    state <= S_DROP;
                end else if (hdr_long) begin
                    state      <= S_PAYLOAD;
                    bytes_left <= hdr_wc;
                    words_left <= 16'((17'(hdr_wc) + 17'd5) >> 2);
                    first_pend <= 1'b1;
                    wr_en      <= hdr_vc_ok && (hdr_dt != DT_NULL) && (hdr_dt != DT_BLANK);
                end else begin
                    state <= S_HDR;
                    if (hdr_vc_ok) begin
                        evt_valid <= 1'b1;
                        evt_dt    <= hdr_dt;
                        evt_data  <= hdr_wc;
                    end
                end
            end else if (accept && state == S_PAYLOAD) begin
                if (n != 3'd0) begin
                    bytes_left <= bytes_left - 16'(n);
                    first_pend <= 1'b0;
                    if (wr_en) begin
                        pix_fifo_write <= 1'b1;
                        pix_fifo_data  <= in_data;
                        pix_fifo_be    <= 4'((5'd1 << n) - 5'd1);
                        pix_fifo_first <= first_pend;
                        pix_fifo_last  <= (bytes_left <= 16'd4);
                    end
                end
                words_left <= words_left - 16'd1;
                if (last_word) state <= S_HDR;
            end
        end
    end

`ifdef DSI_PARSER_CRC_EN
    logic [15:0] crc;
    logic [15:0] crc_nxt;
    logic [15:0] rx_crc;
    logic [15:0] rx_crc_nxt;
    logic [1:0]  chk_left;
    logic [1:0]  chk_cnt;
    logic        chk_en;

    dsi_crc16_4b u_crc (
        .crc_in (crc),
        .data   (in_data),
        .nbytes (n),
        .crc_out(crc_nxt)
    );

    // Checksum bytes sit right after the payload lanes and may spill into the next word.
    always_comb begin
        rx_crc_nxt = rx_crc;
        chk_cnt    = chk_left;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) >= n && chk_cnt != 2'd0) begin
                if (chk_cnt == 2'd2) rx_crc_nxt[7:0] = in_data[8*k +: 8];
                else                 rx_crc_nxt[15:8] = in_data[8*k +: 8];
                chk_cnt = chk_cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc       <= '0;
            rx_crc    <= '0;
            chk_left  <= '0;
            chk_en    <= 1'b0;
            crc_error <= 1'b0;
        end else begin
            crc_error <= 1'b0;
            if (accept && in_sop) begin
                crc      <= 16'hFFFF;
                rx_crc   <= '0;
                chk_left <= 2'd2;
                chk_en   <= hdr_vc_ok;
            end else if (accept && state == S_PAYLOAD) begin
                crc      <= crc_nxt;
                rx_crc   <= rx_crc_nxt;
                chk_left <= chk_cnt;
                if (last_word) crc_error <= chk_en && (crc_nxt != rx_crc_nxt);
            end
        end
    end
`else
    assign crc_error = 1'b0;
`endif

endmodule
